// File: rtl/post_adder_preg.sv
// Post-adder/subtracter Z +/- (X + CIN) with optional P register,
// validity tracking and a sticky signed-overflow flag.
module post_adder_preg #(
    parameter int WIDTH      = 48,
    parameter int PREG       = 1,
    parameter int CARRYINREG = 1
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             SCLR,
    input  logic [WIDTH-1:0] X_IN,
    input  logic [WIDTH-1:0] Z_IN,
    input  logic             SUB,
    input  logic             CARRYIN,
    input  logic             CECARRYIN,
    input  logic             CEP,
    input  logic             VALID_IN,
    input  logic             CLR_OVF,
    output logic [WIDTH-1:0] P,
    output logic             CARRYOUT,
    output logic             VALID_OUT,
    output logic             OVF_STICKY
);

    logic             cin_eff;
    logic [WIDTH:0]   r;
    logic [WIDTH+1:0] s_ext;
    logic [WIDTH+1:0] z_ext;
    logic [WIDTH+1:0] x_ext;
    logic             ovf_next;
    logic             ovf_cap;
    logic             ovf_d;
    logic             ovf_q;

    generate
        if (CARRYINREG != 0) begin : g_cinreg
            logic cin_d;
            logic cin_q;
            assign cin_d = CECARRYIN ? CARRYIN : cin_q;
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) cin_q <= 1'b0;
                else       cin_q <= cin_d;
            end
            assign cin_eff = cin_q;
        end else begin : g_cindir
            assign cin_eff = CARRYIN;
        end
    endgenerate

    // Two guard bits hold the exact signed result, so overflow shows up
    // as a disagreement among the top three bits.
    assign z_ext = {Z_IN[WIDTH-1], Z_IN[WIDTH-1], Z_IN};
    assign x_ext = {X_IN[WIDTH-1], X_IN[WIDTH-1], X_IN};

    always_comb begin
        r     = '0;
        s_ext = '0;
        if (SUB) begin
            r     = {1'b0, Z_IN} - {1'b0, X_IN} - {{WIDTH{1'b0}}, cin_eff};
            s_ext = z_ext - x_ext - {{(WIDTH+1){1'b0}}, cin_eff};
        end else begin
            r     = {1'b0, Z_IN} + {1'b0, X_IN} + {{WIDTH{1'b0}}, cin_eff};
            s_ext = z_ext + x_ext + {{(WIDTH+1){1'b0}}, cin_eff};
        end
    end

    assign ovf_next = (s_ext[WIDTH+1] != s_ext[WIDTH-1])
                   || (s_ext[WIDTH]   != s_ext[WIDTH-1]);

    generate
        if (PREG != 0) begin : g_preg
            logic [WIDTH-1:0] p_d;
            logic [WIDTH-1:0] p_q;
            logic             co_d;
            logic             co_q;
            logic             v_d;
            logic             v_q;

            always_comb begin
                p_d  = p_q;
                co_d = co_q;
                v_d  = v_q;
                if (SCLR) begin
                    p_d  = '0;
                    co_d = 1'b0;
                    v_d  = 1'b0;
                end else if (CEP) begin
                    p_d  = r[WIDTH-1:0];
                    co_d = r[WIDTH];
                    v_d  = VALID_IN;
                end
            end

            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    p_q  <= '0;
                    co_q <= 1'b0;
                    v_q  <= 1'b0;
                end else begin
                    p_q  <= p_d;
                    co_q <= co_d;
                    v_q  <= v_d;
                end
            end

            assign P         = p_q;
            assign CARRYOUT  = co_q;
            assign VALID_OUT = v_q;
            assign ovf_cap   = !SCLR && CEP && VALID_IN && ovf_next;
        end else begin : g_comb
            assign P         = r[WIDTH-1:0];
            assign CARRYOUT  = r[WIDTH];
            assign VALID_OUT = VALID_IN;
            assign ovf_cap   = VALID_IN && ovf_next;
        end
    endgenerate

    // A capture in the same cycle as a clear keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_cap)      ovf_d = 1'b1;
        else if (CLR_OVF) ovf_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign OVF_STICKY = ovf_q;

endmodule

// File: tb/tb_post_adder_preg.sv
// Bench for post_adder_preg: registered and combinational builds
// checked against an integer-arithmetic reference model.
module tb_post_adder_preg;

    localparam int W = 48;
    localparam longint MAXS = (64'sd1 <<< 47) - 64'sd1;
    localparam longint MINS = -(64'sd1 <<< 47);

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         sclr = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic         cecin = 1'b0;
    logic         cep = 1'b0;
    logic         vin = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] x = '0;
    logic [W-1:0] z = '0;

    logic [W-1:0] p1;
    logic         co1, v1, ovf1;
    logic [W-1:0] p0;
    logic         co0, v0, ovf0;

    logic [W-1:0] m_p;
    logic         m_co, m_v, m_ovf, m_cin, m_ovf0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    post_adder_preg #(.WIDTH(W), .PREG(1), .CARRYINREG(1)) u_reg (
        .CLK(clk), .RSTN(rstn), .SCLR(sclr), .X_IN(x), .Z_IN(z),
        .SUB(sub), .CARRYIN(cin), .CECARRYIN(cecin), .CEP(cep),
        .VALID_IN(vin), .CLR_OVF(clr), .P(p1), .CARRYOUT(co1),
        .VALID_OUT(v1), .OVF_STICKY(ovf1)
    );

    post_adder_preg #(.WIDTH(W), .PREG(0), .CARRYINREG(0)) u_comb (
        .CLK(clk), .RSTN(rstn), .SCLR(sclr), .X_IN(x), .Z_IN(z),
        .SUB(sub), .CARRYIN(cin), .CECARRYIN(cecin), .CEP(cep),
        .VALID_IN(vin), .CLR_OVF(clr), .P(p0), .CARRYOUT(co0),
        .VALID_OUT(v0), .OVF_STICKY(ovf0)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic void calc(input logic [W-1:0] a_x, a_z,
                                 input logic a_sub, a_cin,
                                 output logic [W-1:0] o_p,
                                 output logic o_co, o_ovf);
        longint unsigned ux, uz, uc, r;
        longint sx, sz, sc, sr;
        ux = 64'(a_x);
        uz = 64'(a_z);
        uc = 64'(a_cin);
        r  = a_sub ? uz - (ux + uc) : uz + ux + uc;
        o_p  = r[W-1:0];
        o_co = r[W];
        sx = $signed({{16{a_x[W-1]}}, a_x});
        sz = $signed({{16{a_z[W-1]}}, a_z});
        sc = $signed(uc);
        sr = a_sub ? sz - (sx + sc) : sz + sx + sc;
        o_ovf = (sr > MAXS) || (sr < MINS);
    endfunction

    task automatic model_reset();
        m_p = '0; m_co = 0; m_v = 0; m_ovf = 0; m_cin = 0; m_ovf0 = 0;
    endtask

    task automatic tick();
        logic [W-1:0] pc, pn;
        logic coc, ovc, con, ovn;
        #1;
        calc(x, z, sub, cin, pc, coc, ovc);
        chk("comb_p", 64'(p0), 64'(pc));
        chk("comb_co", 64'(co0), 64'(coc));
        chk("comb_v", 64'(v0), 64'(vin));
        calc(x, z, sub, m_cin, pn, con, ovn);
        @(posedge clk);
        #1;
        if (!sclr && cep && vin && ovn) m_ovf = 1'b1;
        else if (clr)                   m_ovf = 1'b0;
        if (vin && ovc)  m_ovf0 = 1'b1;
        else if (clr)    m_ovf0 = 1'b0;
        if (sclr) begin
            m_p = '0; m_co = 0; m_v = 0;
        end else if (cep) begin
            m_p = pn; m_co = con; m_v = vin;
        end
        if (cecin) m_cin = cin;
        chk("reg_p", 64'(p1), 64'(m_p));
        chk("reg_co", 64'(co1), 64'(m_co));
        chk("reg_v", 64'(v1), 64'(m_v));
        chk("reg_ovf", 64'(ovf1), 64'(m_ovf));
        chk("comb_ovf", 64'(ovf0), 64'(m_ovf0));
    endtask

    task automatic op(input logic [W-1:0] a_x, a_z, input logic a_sub);
        x = a_x; z = a_z; sub = a_sub;
        tick();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst_p", 64'(p1), 64'd0);
        chk("rst_co", 64'(co1), 64'd0);
        chk("rst_v", 64'(v1), 64'd0);
        chk("rst_ovf", 64'(ovf1), 64'd0);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        cin = 1; cecin = 1;
        tick();
        cin = 0; vin = 1; cep = 1;
        op(48'd5, 48'd10, 1'b0);
        chk("add_p", 64'(p1), 64'd16);
        chk("add_co", 64'(co1), 64'd0);
        chk("add_v", 64'(v1), 64'd1);

        op(48'hFFFF_FFFF_FFFF, 48'd1, 1'b0);
        chk("cy_p", 64'(p1), 64'd0);
        chk("cy_co", 64'(co1), 64'd1);
        chk("cy_ovf", 64'(ovf1), 64'd0);

        op(48'd5, 48'd3, 1'b1);
        chk("sub_p", 64'(p1), 64'hFFFF_FFFF_FFFE);
        chk("sub_co", 64'(co1), 64'd1);
        chk("sub_ovf", 64'(ovf1), 64'd0);

        op(48'd1, 48'h7FFF_FFFF_FFFF, 1'b0);
        chk("ovf_p", 64'(p1), 64'h8000_0000_0000);
        chk("ovf_set", 64'(ovf1), 64'd1);
        for (int i = 0; i < 3; i++) begin
            op(48'd1, 48'd2, 1'b0);
            chk("ovf_hold", 64'(ovf1), 64'd1);
        end
        clr = 1;
        op(48'd1, 48'd2, 1'b0);
        chk("ovf_clr", 64'(ovf1), 64'd0);
        op(48'd1, 48'h7FFF_FFFF_FFFF, 1'b0);
        chk("ovf_setwin", 64'(ovf1), 64'd1);
        chk("ovf_setwin0", 64'(ovf0), 64'd1);
        clr = 0;

        op(48'd6, 48'd10, 1'b0);
        chk("ce_p16", 64'(p1), 64'd16);
        cep = 0;
        op(48'd1, 48'd1, 1'b0);
        chk("ce_hold", 64'(p1), 64'd16);
        sclr = 1;
        op(48'd3, 48'd3, 1'b0);
        chk("sclr_p", 64'(p1), 64'd0);
        chk("sclr_v", 64'(v1), 64'd0);
        chk("sclr_ovf", 64'(ovf1), 64'd1);
        sclr = 0; cep = 1;

        for (int i = 1; i <= 4; i++) begin
            op(48'd2, p1, 1'b0);
            chk("acc_p", 64'(p1), 64'(2 * i));
        end
        #2 rstn = 0;
        #1;
        model_reset();
        chk("arst_p", 64'(p1), 64'd0);
        chk("arst_v", 64'(v1), 64'd0);
        chk("arst_ovf", 64'(ovf1), 64'd0);
        #2 rstn = 1;

        x = 48'd3; z = 48'd4; sub = 0; cin = 0;
        #1;
        chk("comb_now", 64'(p0), 64'd7);
        tick();

        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] rx, rz;
            rx = {16'($urandom), 32'($urandom)};
            rz = {16'($urandom), 32'($urandom)};
            case ($urandom_range(0, 5))
                0: rz = 48'h7FFF_FFFF_FFFF;
                1: rz = 48'h8000_0000_0000;
                2: rx = 48'hFFFF_FFFF_FFFF;
                default: ;
            endcase
            sclr  = ($urandom_range(0, 15) == 0);
            cep   = ($urandom_range(0, 3) != 0);
            cecin = $urandom_range(0, 1) == 1;
            cin   = $urandom_range(0, 1) == 1;
            clr   = ($urandom_range(0, 7) == 0);
            vin   = ($urandom_range(0, 3) != 0);
            op(rx, rz, $urandom_range(0, 1) == 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/post_adder_preg.md
Name: post_adder_preg

Overview:
- Post-adder/subtracter stage directly downstream of the slice's X and Z operand multiplexers.
- Computes Z ± (X + CIN) at WIDTH bits with carry-out, and optionally registers the result in the P register.
- Tracks data validity through the pipeline and keeps a sticky signed-overflow flag.
- P is fed back to the Z/X multiplexers for accumulate modes.

Parameters:
- WIDTH, 48, operand/result width in bits.
- PREG, 1, 1 = P, CARRYOUT, VALID_OUT registered (latency 1); 0 = combinational (latency 0).
- CARRYINREG, 1, 1 = CARRYIN passes through a register enabled by CECARRYIN; 0 = CARRYIN used directly.

Ports:
- CLK  input  1  clock, rising edge.
- RSTN  input  1  asynchronous active-low reset for all registers.
- SCLR  input  1  synchronous active-high clear of P/CARRYOUT/VALID_OUT registers, honoured regardless of CEP.
- X_IN  input  WIDTH  X multiplexer output.
- Z_IN  input  WIDTH  Z multiplexer output.
- SUB  input  1  0 = Z + (X + CIN); 1 = Z − (X + CIN).
- CARRYIN  input  1  carry-in.
- CECARRYIN  input  1  clock enable, carry-in register.
- CEP  input  1  clock enable, P/CARRYOUT/VALID_OUT registers.
- VALID_IN  input  1  X_IN/Z_IN/SUB valid this cycle.
- CLR_OVF  input  1  clears the sticky overflow flag.
- P  output  WIDTH  result.
- CARRYOUT  output  1  carry/borrow out, bit WIDTH of the internal WIDTH+1 result.
- VALID_OUT  output  1  P valid.
- OVF_STICKY  output  1  sticky signed-overflow flag.

Behaviour:
- Clock and reset: one clock, CLK. Reset RSTN is asynchronous, active-low.
- Reset values: with RSTN=0, P=0, CARRYOUT=0, VALID_OUT=0, OVF_STICKY=0, and the carry-in register=0, immediately and independent of CLK.
- Carry-in path:
  - cin_eff = carry-in register when CARRYINREG=1. That register loads CARRYIN on a CLK edge with CECARRYIN=1 and holds otherwise.
  - cin_eff = CARRYIN when CARRYINREG=0.
  - With CARRYINREG=1, CARRYIN must be presented one cycle ahead of X_IN/Z_IN (aligned with the upstream M-register stage).
- Arithmetic: unsigned WIDTH+1-bit operation on zero-extended operands.
  - Add: r = {0,Z} + {0,X} + cin_eff.
  - Sub: r = {0,Z} − ({0,X} + cin_eff), modulo 2^(WIDTH+1).
  - p_next = r[WIDTH-1:0]; co_next = r[WIDTH]. In subtract mode, co_next=1 indicates borrow.
- Signed overflow: ovf_next = 1 when the exact signed result of sign-extended Z ± (sign-extended X + cin_eff) lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- PREG=1, on each CLK edge, in this priority:
  1. SCLR=1 → P, CARRYOUT, VALID_OUT ← 0.
  2. Else CEP=1 → P ← p_next, CARRYOUT ← co_next, VALID_OUT ← VALID_IN.
  3. Else all three hold.
- PREG=0: P=p_next, CARRYOUT=co_next, VALID_OUT=VALID_IN, all combinational. SCLR and CEP have no effect.
- Overflow capture event:
  - PREG=1: a CLK edge with SCLR=0, CEP=1, VALID_IN=1 and ovf_next=1.
  - PREG=0: a CLK edge with VALID_IN=1 and ovf_next=1.
- OVF_STICKY is always registered:
  - Set on a capture event.
  - Cleared on a CLK edge with CLR_OVF=1.
  - A simultaneous set and clear leaves it at 1 (set wins).
  - SCLR does not affect it.
- Accumulate: feeding P back through the Z multiplexer with PREG=1 and CEP=1 every cycle adds X each cycle. No internal feedback path exists.
- Reset mid-operation: asserting RSTN low discards the in-flight result and the carry-in register contents. The first valid output after release appears one CEP-enabled edge after VALID_IN=1.
- X/Z values with VALID_IN=0 are still computed and registered into P. Only VALID_OUT and the overflow flag are qualified by validity.

Test Plan (WIDTH=48, PREG=1, CARRYINREG=1 unless stated):
- Reset/add:
  - RSTN low, then release.
  - Edge 1: CARRYIN=1, CECARRYIN=1. Edge 2: X=5, Z=10, SUB=0, VALID_IN=1, CEP=1.
  - Required: P=16, CARRYOUT=0, VALID_OUT=1 one cycle after edge 2.
- Carry-out:
  - X=48'hFFFF_FFFF_FFFF, Z=1, cin=0, add.
  - Required: P=0, CARRYOUT=1, OVF_STICKY stays 0 (signed −1+1=0).
- Subtract/borrow:
  - Z=3, X=5, cin=0, SUB=1.
  - Required: P=48'hFFFF_FFFF_FFFE, CARRYOUT=1, no overflow.
- Overflow sticky:
  - Z=48'h7FFF_FFFF_FFFF, X=1, add, valid.
  - Required: P=48'h8000_0000_0000, OVF_STICKY=1 that cycle. It stays 1 through 3 further non-overflow ops.
  - Then CLR_OVF pulse → 0. CLR_OVF asserted together with a new overflow event → remains 1.
- CE/SCLR priority:
  - P=16. Edge with CEP=0, new X/Z → P holds 16.
  - Edge with SCLR=1, CEP=0 → P=0, VALID_OUT=0.
- Async reset mid-accumulate:
  - Accumulate X=2 for 4 cycles (P: 2,4,6,8).
  - Drop RSTN between edges → P=0 and VALID_OUT=0 before the next edge.
  - PREG=0 variant: P follows Z+X combinationally within the same cycle.
